// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that consumes DIGIT bits per clock, LSB first.
//
// Latches two WIDTH-bit operands and a carry-in on an accepted start. It then
// runs N = WIDTH/DIGIT steps. It reports {carry, sum} = a + b + cin, plus
// two's-complement overflow, and raises a one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port (a - b).
//
// Parameters:
//   WIDTH    operand/sum width (>= 1)
//   DIGIT    bits added per clock; must divide WIDTH
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request, accepted when busy=0 (including the done cycle)
//   a, b     operands, sampled with start
//   cin      carry-in, sampled with start
//   sub      subtract select, sampled with start (SERIAL_ADDER_SUB_EN only)
//   busy     operation in progress
//   done     one-cycle result-valid pulse
//   sum      result, held until the next accepted start completes a step
//   carry    carry out of bit WIDTH-1 (1 = no borrow when subtracting)
//   overflow carry into MSB xor carry out of MSB
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   dc;      // ripple carries through the current digit
  logic [WIDTH-1:0] dsum_ext;
  logic             last;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  // Digit-wide ripple adder on the low DIGIT bits of the operand shifters.
  always_comb begin
    dsum  = '0;
    dc    = '0;
    dc[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_q[i] ^ b_q[i] ^ dc[i];
      dc[i+1]  = (a_q[i] & b_q[i]) | (dc[i] & (a_q[i] ^ b_q[i]));
    end
    dsum_ext = WIDTH'(dsum);
  end

  // Subtraction is a + ~b + 1, so it is folded into operand/carry load.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_in = sub ? ~b : b;
    c_in = sub ? 1'b1 : cin;
`else
    b_in = b;
    c_in = cin;
`endif
  end

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b_in;
          carry_d = c_in;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // New digit enters at the MSB end; after N steps the digits have
        // settled into their final positions.
        sum_d   = (sum_q >> DIGIT) | (dsum_ext << (WIDTH - DIGIT));
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dc[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          // The top bit of the final digit is bit WIDTH-1.
          ovf_d   = dc[DIGIT] ^ dc[DIGIT-1];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule
